seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/hex_to_seg7.sv | 12 +
 rtl/seg7_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Holds the scan state enum, the hex segment table and the blank pattern.
package seg7_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}: 0..9, A, b, C, d, E, F
   localparam logic [6:0] SEG7_HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Ports: nib (4-bit value in), seg_n ({g,f,e,d,c,b,a}, active-low out).
import seg7_pkg::*;

module hex_to_seg7 (
   input  logic [3:0] nib,
   output logic [6:0] seg_n
);

   always_comb seg_n = SEG7_HEX[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Ports: clk, reset_n (async, active-low); wr_valid/wr_ready/wr_data/wr_dp
// write port, values committed at frame end; bright (4-bit duty, only with
// SEG7_BRIGHTNESS_EN defined); seg_n, dp_n, dig_n (active-low drives);
// frame_done (pulse on the last drive cycle of the last digit).
import seg7_pkg::*;

module seg7_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int SLOT_CYCLES  = 4096,
   parameter int BLANK_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [4*DIGITS-1:0]   wr_data,
   input  logic [DIGITS-1:0]     wr_dp,
`ifdef SEG7_BRIGHTNESS_EN
   input  logic [3:0]            bright,
`endif
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     dig_n,
   output logic                  frame_done
);

   localparam int CMAX = (SLOT_CYCLES > BLANK_CYCLES) ?
                         SLOT_CYCLES : BLANK_CYCLES;
   localparam int CW   = $clog2(CMAX);
   localparam int DW   = $clog2(DIGITS);

   scan_state_t          state;
   logic [DW-1:0]        digit;
   logic [CW-1:0]        cnt;
   logic [4*DIGITS-1:0]  act_data;
   logic [DIGITS-1:0]    act_dp;
   logic [4*DIGITS-1:0]  pend_data;
   logic [DIGITS-1:0]    pend_dp;
   logic                 pend_full;
`ifdef SEG7_BRIGHTNESS_EN
   logic [3:0]           bright_q;
`endif

   logic [3:0] nib;
   logic [6:0] seg_dec;
   logic       lit;
   logic       slot_end;
   logic       blank_end;
   logic       last;
   logic       accept;

   always_comb begin
      nib       = act_data[digit*4 +: 4];
      slot_end  = (cnt == CW'(SLOT_CYCLES - 1));
      blank_end = (cnt == CW'(BLANK_CYCLES - 1));
      last      = (state == DRIVE) && slot_end &&
                  (digit == DW'(DIGITS - 1));
      accept    = wr_valid && wr_ready;
`ifdef SEG7_BRIGHTNESS_EN
      // PWM within each 16-cycle block of the slot
      lit       = (cnt[3:0] <= bright_q);
`else
      lit       = 1'b1;
`endif
   end

   hex_to_seg7 u_dec (
      .nib   (nib),
      .seg_n (seg_dec)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= BLANK;
         digit      <= '0;
         cnt        <= '0;
         act_data   <= '0;
         act_dp     <= '0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_full  <= 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
         bright_q   <= 4'd0;
`endif
         seg_n      <= SEG_OFF;
         dp_n       <= 1'b1;
         dig_n      <= '1;
         frame_done <= 1'b0;
         wr_ready   <= 1'b1;
      end else begin
         // Outputs reflect the state held during the cycle just ended
         seg_n      <= SEG_OFF;
         dp_n       <= 1'b1;
         dig_n      <= '1;
         frame_done <= last;
         if (state == DRIVE) begin
            seg_n <= seg_dec;
            dp_n  <= ~act_dp[digit];
            if (lit) dig_n <= ~(DIGITS'(1) << digit);
         end

         // Ready stays low one extra cycle after a commit frees the buffer
         wr_ready <= !accept && !pend_full;

         if (last && pend_full) begin
            act_data  <= pend_data;
            act_dp    <= pend_dp;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
         end else if (accept) begin
            pend_data <= wr_data;
            pend_dp   <= wr_dp;
            pend_full <= 1'b1;
         end

         case (state)
            BLANK: begin
               if (blank_end) begin
                  state <= DRIVE;
                  cnt   <= '0;
`ifdef SEG7_BRIGHTNESS_EN
                  bright_q <= bright;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRIVE: begin
               if (slot_end) begin
                  state <= BLANK;
                  cnt   <= '0;
                  digit <= (digit == DW'(DIGITS - 1)) ?
                           '0 : digit + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= BLANK;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIGITS=4, SLOT=16, BLANK=2).
// Frame-position model plus directed literal checks.
module tb_seg7_scan_ctrl;

   localparam int D     = 4;
   localparam int S     = 16;
   localparam int B     = 2;
   localparam int SLOTP = S + B;
   localparam int FRAME = D * SLOTP;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [15:0]   wr_data = '0;
   logic [3:0]    wr_dp = '0;
`ifdef SEG7_BRIGHTNESS_EN
   logic [3:0]    bright = 4'd15;
`endif
   logic [6:0]    seg_n;
   logic          dp_n;
   logic [3:0]    dig_n;
   logic          frame_done;

   int n_run = 0;
   int n_fail = 0;

   // model state
   int          cyc = 0;
   logic        pend_v = 1'b0;
   logic [15:0] pend_d = '0;
   logic [3:0]  pend_p = '0;
   logic [15:0] act = '0;
   logic [3:0]  actdp = '0;
   logic [3:0]  bq = 4'd15;
   logic [6:0]  e_seg = 7'h7F;
   logic        e_dp = 1'b1;
   logic [3:0]  e_dig = 4'hF;
   logic        e_fd = 1'b0;
   logic        e_rdy = 1'b1;

   seg7_scan_ctrl #(
      .DIGITS       (D),
      .SLOT_CYCLES  (S),
      .BLANK_CYCLES (B)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .wr_dp      (wr_dp),
`ifdef SEG7_BRIGHTNESS_EN
      .bright     (bright),
`endif
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .dig_n      (dig_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hexseg(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;
         4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;
         4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;
         4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic check(input string nm, input logic [15:0] a,
                        input logic [15:0] e);
      n_run++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cyc %0d)",
                  nm, a, e, cyc);
      end
   endtask

   // Model: cyc is the index of the cycle ending at this edge,
   // counted from reset release; outputs after the edge show it.
   always @(posedge clk) begin
      int p, slot, off;
      logic acc;
      if (!reset_n) begin
         cyc    <= 0;
         pend_v <= 1'b0;
         pend_d <= '0;
         pend_p <= '0;
         act    <= '0;
         actdp  <= '0;
         bq     <= 4'd15;
         e_seg  <= 7'h7F;
         e_dp   <= 1'b1;
         e_dig  <= 4'hF;
         e_fd   <= 1'b0;
         e_rdy  <= 1'b1;
      end else begin
         p    = cyc % FRAME;
         slot = p / SLOTP;
         off  = p % SLOTP;
`ifdef SEG7_BRIGHTNESS_EN
         if (off == B - 1) bq <= bright;
`endif
         e_seg <= 7'h7F;
         e_dp  <= 1'b1;
         e_dig <= 4'hF;
         if (off >= B) begin
            e_seg <= hexseg(act[slot*4 +: 4]);
            e_dp  <= ~actdp[slot];
            if (((off - B) % 16) <= int'(bq))
               e_dig <= ~(4'b0001 << slot);
         end
         e_fd  <= (p == FRAME - 1);
         acc   = wr_valid && e_rdy;
         e_rdy <= !acc && !pend_v;
         if (p == FRAME - 1 && pend_v) begin
            act    <= pend_d;
            actdp  <= pend_p;
            pend_v <= 1'b0;
         end else if (acc) begin
            pend_d <= wr_data;
            pend_p <= wr_dp;
            pend_v <= 1'b1;
         end
         cyc <= cyc + 1;
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      check("seg_n", 16'(seg_n), 16'(e_seg));
      check("dp_n", 16'(dp_n), 16'(e_dp));
      check("dig_n", 16'(dig_n), 16'(e_dig));
      check("frame_done", 16'(frame_done), 16'(e_fd));
      check("wr_ready", 16'(wr_ready), 16'(e_rdy));
   end

   task automatic at(input int m);
      int g = 0;
      while (cyc != m && g < 1000) begin
         @(negedge clk);
         g++;
      end
      if (cyc != m) check("reach_cycle", 16'(cyc), 16'(m));
   endtask

   task automatic put(input logic [15:0] d, input logic [3:0] dp);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_dp    = dp;
      @(negedge clk);
      wr_valid = 1'b0;
      wr_data  = 16'hEEEE;
      wr_dp    = 4'h0;
   endtask

   initial begin
      int k, n, exp_lo;
      repeat (3) @(negedge clk);
      check("rst_seg", 16'(seg_n), 16'h7F);
      check("rst_dp", 16'(dp_n), 16'h1);
      check("rst_dig", 16'(dig_n), 16'hF);
      check("rst_fd", 16'(frame_done), 16'h0);
      check("rst_rdy", 16'(wr_ready), 16'h1);
      reset_n = 1'b1;

      // first drive latency
      k = 0;
      while (dig_n == 4'hF && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("first_drive", 16'(k), 16'd3);
      check("first_dig", 16'(dig_n), 16'hE);
      check("first_seg", 16'(seg_n), 16'h40);
      at(72);
      check("fd_72", 16'(frame_done), 16'h1);
      at(73);
      check("fd_73", 16'(frame_done), 16'h0);

      // pending value then reset during DRIVE(2)
      at(150);
      put(16'hFFFF, 4'hF);
      check("rdy_drop", 16'(wr_ready), 16'h0);
      at(190);
      check("pre_rst_dig", 16'(dig_n), 16'hB);
      #2 reset_n = 1'b0;
      #1;
      check("arst_seg", 16'(seg_n), 16'h7F);
      check("arst_dig", 16'(dig_n), 16'hF);
      check("arst_dp", 16'(dp_n), 16'h1);
      check("arst_rdy", 16'(wr_ready), 16'h1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      at(3);
      check("post_rst_seg", 16'(seg_n), 16'h40);
      check("post_rst_dig", 16'(dig_n), 16'hE);
      check("post_rst_rdy", 16'(wr_ready), 16'h1);

      // mid-frame write commits at frame end
      at(100);
      put(16'h1234, 4'b0001);
      at(130);
      check("old_frame_d3", 16'(seg_n), 16'h40);
      at(144);
      check("commit_fd", 16'(frame_done), 16'h1);
      check("commit_rdy0", 16'(wr_ready), 16'h0);
      at(145);
      check("commit_rdy1", 16'(wr_ready), 16'h1);
      at(150);
      check("d0_seg", 16'(seg_n), 16'h19);
      check("d0_dp", 16'(dp_n), 16'h0);
      check("d0_dig", 16'(dig_n), 16'hE);
      at(205);
      check("d3_seg", 16'(seg_n), 16'h79);
      check("d3_dp", 16'(dp_n), 16'h1);
      check("d3_dig", 16'(dig_n), 16'h7);

      // valid held a whole frame: only the first beat lands
      at(216);
      wr_valid = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         wr_data = (i == 0) ? 16'hABCD : 16'(16'h5678 + i);
         wr_dp   = (i == 0) ? 4'b1000 : 4'(i);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      check("hold_fd", 16'(frame_done), 16'h1);
      check("hold_rdy0", 16'(wr_ready), 16'h0);
      @(negedge clk);
      check("hold_rdy1", 16'(wr_ready), 16'h1);
      at(295);
      check("beat0_d0", 16'(seg_n), 16'h21);
      check("beat0_dp0", 16'(dp_n), 16'h1);
      at(350);
      check("beat0_d3", 16'(seg_n), 16'h08);
      check("beat0_dp3", 16'(dp_n), 16'h0);

      // accept on the final drive cycle of the last digit
      at(431);
      put(16'h9000, 4'h0);
      check("late_rdy", 16'(wr_ready), 16'h0);
      at(495);
      check("late_nocommit", 16'(seg_n), 16'h08);
      at(504);
      check("late_fd", 16'(frame_done), 16'h1);
      check("late_rdy0", 16'(wr_ready), 16'h0);
      at(505);
      check("late_rdy1", 16'(wr_ready), 16'h1);
      at(565);
      check("late_commit", 16'(seg_n), 16'h10);
      check("late_dp", 16'(dp_n), 16'h1);

      // duty within one digit-0 slot
`ifdef SEG7_BRIGHTNESS_EN
      at(575);
      bright = 4'd3;
      exp_lo = 4;
`else
      exp_lo = 16;
`endif
      at(579);
      n = 0;
      for (int i = 0; i < S; i++) begin
         if (!dig_n[0]) n++;
         @(negedge clk);
      end
      check("duty_count", 16'(n), 16'(exp_lo));
      at(600);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end, %0d failed", n_fail);
      $fatal(1);
   end

endmodule
